if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction fetch queue between the program counter / instruction memory (IF) and the decode stage (ID) of the five-stage pipeline. Each cycle IF offers one {PC, instruction} pair; the queue buffers up to DEPTH pairs so that fetch can run ahead while decode stalls. It presents the oldest pair to ID with a derived PC+8 link value and an address-alignment fault flag, and discards all buffered pairs on a branch/jump redirect.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- clk  input  1  pipeline clock; all state changes on the rising edge
- clr  input  1  reset, synchronous, active-high; highest priority
- in_valid  input  1  IF offers a pair this cycle
- in_ready  output  1  queue can accept a pair (not full)
- in_pc  input  32  fetch address of offered instruction
- in_instr  input  32  instruction word read at in_pc
- out_valid  output  1  head entry valid for ID
- out_ready  input  1  ID consumes the head this cycle (ID not stalled)
- out_pc  output  32  PC of head entry
- out_instr  output  32  instruction of head entry
- out_pc8  output  32  out_pc + 8 (jal/jalr link value)
- out_adel  output  1  head entry was fetched from a misaligned address
- flush  input  1  redirect from ID/EX; discard every buffered entry
- count  output  log2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0], adel}; circular buffer with write pointer, read pointer, and an occupancy counter.
- Push: in_valid && in_ready. The queue writes {in_pc, in_instr, in_pc[1:0]!=2'b00} at the write pointer, and the write pointer advances modulo DEPTH.
- Pop: out_valid && out_ready. The read pointer advances modulo DEPTH.
- count next = count + push − pop. A simultaneous push and pop leaves count unchanged.
- in_ready = (count != DEPTH). This is combinational from count only. A push is refused when the queue is full, even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- Head outputs are show-ahead: combinational from the entry at the read pointer.
  - When the queue is empty, out_pc = 0, out_instr = 0x00000000 (nop bubble), out_adel = 0, and out_pc8 = 8.
- out_pc8 is a 32-bit sum; carry-out is discarded, so 0xFFFFFFFC wraps to 0x00000004.
- Priority each cycle: clr > flush > push/pop.
- flush: count, both pointers ← 0. Any push or pop in the same cycle is ignored, so the pair offered that cycle is dropped. Entry contents need not be cleared.
- clr: same effect as flush. It also applies mid-operation with the queue partly full.
- out_ready while out_valid = 0 has no effect. in_valid while in_ready = 0 has no effect, and IF must hold the pair.

## Timing
- Reset values (cycle after clr is asserted):
  - count = 0, out_valid = 0, in_ready = 1
  - out_pc = 0, out_instr = 0, out_adel = 0, out_pc8 = 8
- Latency: a pair pushed at edge T appears on the head outputs after edge T when the queue was empty. There is no same-cycle bypass from in_* to out_*.
- Throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH−1.
- in_ready, out_valid and count change only after a clock edge and never depend combinationally on in_valid, out_ready or flush.
- A flush asserted at edge T leaves out_valid = 0 after T. The first post-redirect pair can be pushed at edge T+1 and is visible after T+1.

## Test plan
- Reset: assert clr for 1 cycle with the queue holding 3 entries. After that cycle, count = 0, out_valid = 0, in_ready = 1, out_instr = 0, out_pc8 = 8.
- Fill and stall: out_ready = 0; push PCs 0x3000, 0x3004, 0x3008, 0x300C. After 4 edges, count = 4 and in_ready = 0. A fifth push of 0x3010 is refused and count stays 4. Head is 0x3000 with out_pc8 = 0x3008.
- Full with simultaneous pop: from full, in_valid = 1 and out_ready = 1 for one edge. Count = 3, the head becomes 0x3004, and the offered pair is not stored.
- Wrap-around: run 10 pushes and pops concurrently at count = 2. The popped PCs are strictly in push order across pointer wrap, and count stays 2.
- Flush with push: count = 3; in the same cycle assert flush, in_valid with 0x4000, and out_ready. Count becomes 0 and out_valid = 0. The next-cycle push of 0x4000 appears as head one edge later.
- Misalignment: push in_pc = 0x3002. When it reaches the head, out_adel = 1 and out_pc8 = 0x300A. A subsequent aligned entry shows out_adel = 0.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, adel} with
// show-ahead head outputs, a PC+8 link value and redirect flush.
module if_id_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc8,
  output logic                     out_adel,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [31:0]      r_pc    [DEPTH];
  logic [31:0]      r_instr [DEPTH];
  logic [DEPTH-1:0] r_adel;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_redirect;

  assign w_full     = (r_count == L_FULL);
  assign w_empty    = (r_count == '0);
  assign w_redirect = clr || flush;
  // Full refuses a push even when a pop frees a slot this cycle.
  assign w_push     = in_valid && !w_full && !w_redirect;
  assign w_pop      = out_ready && !w_empty && !w_redirect;

  always_ff @(posedge clk) begin
    if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage is not cleared on redirect; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wptr]    <= in_pc;
      r_instr[r_wptr] <= in_instr;
      r_adel[r_wptr]  <= (in_pc[1:0] != 2'b00);
    end
  end

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    out_adel  = 1'b0;
    if (!w_empty) begin
      out_pc    = r_pc[r_rptr];
      out_instr = r_instr[r_rptr];
      out_adel  = r_adel[r_rptr];
    end
  end

  assign out_pc8   = out_pc + 32'd8;
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign count     = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue with DEPTH = 4.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc8;
  logic        out_adel;
  logic        flush = 1'b0;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pc8(out_pc8), .out_adel(out_adel), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    in_valid = 1'b1; in_pc = pc; in_instr = pc ^ 32'hA5A5_0000;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic test_reset();
    do_clr();
    push(32'h1000); push(32'h1004); push(32'h1008);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_reset_count got %0d exp 3", count); end
    do_clr();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h exp 0", out_pc); end
    checks++; if (out_pc8 !== 32'h8) begin errors++; $display("FAIL reset_out_pc8 got %h exp 8", out_pc8); end
    checks++; if (out_adel !== 1'b0) begin errors++; $display("FAIL reset_out_adel got %b exp 0", out_adel); end
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0;
    // Offer a pair with an empty queue: no same-cycle bypass to the head.
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3000 ^ 32'hA5A5_0000;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", out_valid); end
    tick(); in_valid = 1'b0;
    checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL latency_head got %h exp 3000", out_pc); end
    push(32'h3004); push(32'h3008); push(32'h300C);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    push(32'h3010);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL refused_count got %0d exp 4", count); end
    checks++; if (out_pc !== 32'h3000) begin errors++; $display("FAIL full_head got %h exp 3000", out_pc); end
    checks++; if (out_pc8 !== 32'h3008) begin errors++; $display("FAIL full_pc8 got %h exp 3008", out_pc8); end
    checks++; if (out_instr !== 32'hA5A5_3000) begin errors++; $display("FAIL full_instr got %h exp a5a53000", out_instr); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc;
    in_valid = 1'b1; in_pc = 32'h3010; in_instr = 32'hDEAD_BEEF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got %0d exp 3", count); end
    checks++; if (out_pc !== 32'h3004) begin errors++; $display("FAIL fullpop_head got %h exp 3004", out_pc); end
    // Drain: 0x3010 must not appear.
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h3004 + 32'(4 * i);
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL drain_pc got %h exp %h", out_pc, exp_pc); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL pop_empty_count got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_clr();
    push(32'h5000); push(32'h5004);
    for (int k = 0; k < 10; k++) begin
      exp_pc = 32'h5000 + 32'(4 * k);
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, out_pc, exp_pc); end
      in_valid = 1'b1; in_pc = 32'h5008 + 32'(4 * k); in_instr = 32'h0; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", k, count); end
    end
    checks++; if (out_pc !== 32'h5028) begin errors++; $display("FAIL wrap_final_head got %h exp 5028", out_pc); end
  endtask

  task automatic test_flush();
    push(32'h502C);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL preflush_count got %0d exp 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4000; in_instr = 32'h1234_5678; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h4000) begin errors++; $display("FAIL postflush_head got %h exp 4000", out_pc); end
    checks++; if (out_instr !== 32'h1234_5678) begin errors++; $display("FAIL postflush_instr got %h exp 12345678", out_instr); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL postflush_count got %0d exp 1", count); end
  endtask

  task automatic test_misalign();
    do_clr();
    push(32'h3002); push(32'h3008); push(32'hFFFF_FFFC);
    checks++; if (out_adel !== 1'b1) begin errors++; $display("FAIL adel_set got %b exp 1", out_adel); end
    checks++; if (out_pc8 !== 32'h300A) begin errors++; $display("FAIL adel_pc8 got %h exp 300a", out_pc8); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_adel !== 1'b0) begin errors++; $display("FAIL adel_clear got %b exp 0", out_adel); end
    checks++; if (out_pc !== 32'h3008) begin errors++; $display("FAIL adel_next_pc got %h exp 3008", out_pc); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_pc8 !== 32'h4) begin errors++; $display("FAIL pc8_wrap got %h exp 4", out_pc8); end
  endtask

  initial begin
    tick();
    test_reset();
    test_fill_stall();
    test_full_pop();
    test_wrap();
    test_flush();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
